analog_pad_sequencer: RTL and testbench



---
 rtl/analog_pad_sequencer.sv | 171 +++++++++++++++++
 tb/tb_analog_pad_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/analog_pad_sequencer.sv
// Break-before-make sequencer for pads shared between user digital logic and the opamp's analog pins.
// A Wishbone register window configures the guard time and the digital pad values.
module analog_pad_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter int NPADS = 6,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] GUARD_RST = 16'd64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NPADS-1:0] io_oeb,
  output logic [NPADS-1:0] io_out,
  output logic             analog_ready,
  output logic             irq
);

  localparam logic [1:0] ST_DIGITAL    = 2'd0;
  localparam logic [1:0] ST_DISCONNECT = 2'd1;
  localparam logic [1:0] ST_ANALOG     = 2'd2;
  localparam logic [1:0] ST_RELEASE    = 2'd3;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_GUARD   = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_DIG_OUT = 3'd3;
  localparam logic [2:0] OFF_DIG_OEB = 3'd4;

  logic [1:0]       ctrl_reg;
  logic [CNT_W-1:0] guard_reg;
  logic [NPADS-1:0] dig_out_reg;
  logic [NPADS-1:0] dig_oeb_reg;
  logic             evt_reg;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic [NPADS-1:0] io_oeb_reg, io_out_reg;
  logic             analog_ready_reg;

  logic        hit, access, wr;
  logic [2:0]  off;
  logic [31:0] wmask;
  logic [31:0] rd_data;
  logic        req, evt_set, evt_w1c;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i, wmask};

  assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access = hit & ~ack_reg;
  assign wr     = access & wbs_we_i;
  assign off    = wbs_adr_i[4:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  always_comb begin
    rd_data = 32'd0;
    case (off)
      OFF_CTRL:    rd_data = 32'(ctrl_reg);
      OFF_GUARD:   rd_data = 32'(guard_reg);
      OFF_STATUS:  rd_data = {27'd0, evt_reg, 2'b00, state_reg};
      OFF_DIG_OUT: rd_data = 32'(dig_out_reg);
      OFF_DIG_OEB: rd_data = 32'(dig_oeb_reg);
      default:     rd_data = 32'd0;
    endcase
  end

  assign req = ctrl_reg[0] & ~ctrl_reg[1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_DIGITAL: begin
        if (req) begin
          state_next = ST_DISCONNECT;
          cnt_next   = guard_reg;
        end
      end
      ST_DISCONNECT: begin
        if (!req) begin
          state_next = ST_RELEASE;
          cnt_next   = guard_reg;
        end else if (cnt_reg == '0) begin
          state_next = ST_ANALOG;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_ANALOG: begin
        if (!req) begin
          state_next = ST_RELEASE;
          cnt_next   = guard_reg;
        end
      end
      default: begin
        // RELEASE always runs to completion, even if re-enabled meanwhile.
        if (cnt_reg == '0) begin
          state_next = ST_DIGITAL;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
    endcase
  end

  assign evt_set = (state_next == ST_ANALOG) && (state_reg != ST_ANALOG);
  assign evt_w1c = wr && (off == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[4];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_reg         <= 2'b00;
      guard_reg        <= GUARD_RST;
      dig_out_reg      <= '0;
      dig_oeb_reg      <= '1;
      evt_reg          <= 1'b0;
      state_reg        <= ST_DIGITAL;
      cnt_reg          <= '0;
      ack_reg          <= 1'b0;
      dat_reg          <= 32'd0;
      io_oeb_reg       <= '1;
      io_out_reg       <= '0;
      analog_ready_reg <= 1'b0;
    end else begin
      ack_reg <= access;
      dat_reg <= access ? rd_data : 32'd0;
      if (wr) begin
        case (off)
          OFF_CTRL:    ctrl_reg    <= (ctrl_reg & ~wmask[1:0]) | (wbs_dat_i[1:0] & wmask[1:0]);
          OFF_GUARD:   guard_reg   <= (guard_reg & ~wmask[CNT_W-1:0]) | (wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
          OFF_DIG_OUT: dig_out_reg <= (dig_out_reg & ~wmask[NPADS-1:0]) | (wbs_dat_i[NPADS-1:0] & wmask[NPADS-1:0]);
          OFF_DIG_OEB: dig_oeb_reg <= (dig_oeb_reg & ~wmask[NPADS-1:0]) | (wbs_dat_i[NPADS-1:0] & wmask[NPADS-1:0]);
          default: ;
        endcase
      end
      // A set landing with a W1C wins.
      evt_reg   <= evt_set | (evt_reg & ~evt_w1c);
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_next == ST_DIGITAL) begin
        io_oeb_reg <= dig_oeb_reg | {NPADS{ctrl_reg[1]}};
        io_out_reg <= dig_out_reg & ~{NPADS{ctrl_reg[1]}};
      end else begin
        io_oeb_reg <= '1;
        io_out_reg <= '0;
      end
      analog_ready_reg <= (state_next == ST_ANALOG);
    end
  end

  assign wbs_ack_o    = ack_reg;
  assign wbs_dat_o    = dat_reg;
  assign io_oeb       = io_oeb_reg;
  assign io_out       = io_out_reg;
  assign analog_ready = analog_ready_reg;
  assign irq          = evt_reg;

endmodule

// File: tb/tb_analog_pad_sequencer.sv
// Directed bench for analog_pad_sequencer: register table plus hand-written sequencing scenarios.
module tb_analog_pad_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic [5:0]  io_oeb, io_out;
  logic        analog_ready, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  analog_pad_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_oeb(io_oeb), .io_out(io_out), .analog_ready(analog_ready), .irq(irq)
  );

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Returns on the negedge after the ack cycle; a write has committed on the preceding posedge.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic got);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got = 1'b0; rd = 32'd0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        rd  = rdat;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] rd;
    logic got;
    wb_access(1'b1, BASE | 32'(off), d, 4'hF, rd, got);
    check($sformatf("write ack 0x%02h", off), 32'(got), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic got;
    wb_access(1'b0, BASE | 32'(off), 32'd0, 4'hF, rd, got);
    check({name, " ack"}, 32'(got), 32'd1);
    check(name, rd, exp);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic got;
    logic [3:0] ack_pat;

    vecs[0]  = '{1'b0, 8'h04, 32'h0,         4'hF, 32'h40};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h3F};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h0};
    vecs[3]  = '{1'b0, 8'h08, 32'h0,         4'hF, 32'h0};
    vecs[4]  = '{1'b1, 8'h04, 32'h0000_FF00, 4'h2, 32'h0};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,         4'hF, 32'hFF40};
    vecs[6]  = '{1'b1, 8'h0C, 32'h15,        4'hF, 32'h0};
    vecs[7]  = '{1'b0, 8'h0C, 32'h0,         4'hF, 32'h15};
    vecs[8]  = '{1'b1, 8'h10, 32'h2A,        4'hF, 32'h0};
    vecs[9]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h2A};
    vecs[10] = '{1'b1, 8'h14, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 8'h14, 32'h0,         4'hF, 32'h0};
    vecs[12] = '{1'b0, 8'h1C, 32'h0,         4'hF, 32'h0};
    vecs[13] = '{1'b1, 8'h10, 32'h0000_FF3F, 4'h0, 32'h0};
    vecs[14] = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h2A};

    // Reset state
    wait_neg(3);
    check("rst io_oeb", 32'(io_oeb), 32'h3F);
    check("rst io_out", 32'(io_out), 32'h0);
    check("rst analog_ready", 32'(analog_ready), 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    check("rst ack", 32'(ack), 32'h0);
    check("rst dat_o", rdat, 32'h0);
    rst = 1'b0;
    wait_neg(1);

    // Register table
    for (int i = 0; i < 15; i++) begin
      wb_access(vecs[i].we, BASE | 32'(vecs[i].off), vecs[i].dat, vecs[i].sel, rd, got);
      check($sformatf("vec%0d ack", i), 32'(got), 32'd1);
      if (!vecs[i].we) check($sformatf("vec%0d rd 0x%02h", i, vecs[i].off), rd, vecs[i].exp);
    end
    wait_neg(1);
    check("digital io_oeb", 32'(io_oeb), 32'h2A);
    check("digital io_out", 32'(io_out), 32'h15);

    // Back-to-back on unmapped offset: ack every other cycle, data 0
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h1C; sel = 4'hF;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      ack_pat[i] = ack;
      if (ack) check("unmapped dat_o", rdat, 32'h0);
    end
    stb = 1'b0; cyc = 1'b0;
    check("ack pattern", 32'(ack_pat), 32'hA);

    // Out-of-window
    wb_access(1'b0, 32'h3000_0204, 32'd0, 4'hF, rd, got);
    check("out-of-window ack", 32'(got), 32'd0);

    // Enable path, GUARD=3
    wr(8'h04, 32'd3);
    wr(8'h00, 32'd1);
    wait_neg(1);
    check("en io_oeb", 32'(io_oeb), 32'h3F);
    check("en io_out", 32'(io_out), 32'h0);
    wait_neg(3);
    check("en ready before", 32'(analog_ready), 32'd0);
    wait_neg(1);
    check("en ready after", 32'(analog_ready), 32'd1);
    check("en irq", 32'(irq), 32'd1);
    rd_chk("en status", 8'h08, 32'h12);

    // Disable path
    wr(8'h00, 32'd0);
    check("dis ready hold", 32'(analog_ready), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      wait_neg(1);
      check($sformatf("dis guard io_oeb c%0d", i), 32'(io_oeb), 32'h3F);
      check($sformatf("dis ready c%0d", i), 32'(analog_ready), 32'd0);
    end
    wait_neg(1);
    check("dis io_oeb", 32'(io_oeb), 32'h2A);
    check("dis io_out", 32'(io_out), 32'h15);
    rd_chk("dis status", 8'h08, 32'h10);
    wr(8'h08, 32'h10);
    check("w1c irq", 32'(irq), 32'd0);
    rd_chk("w1c status", 8'h08, 32'h0);

    // Abort during DISCONNECT, GUARD=10
    wr(8'h04, 32'd10);
    wr(8'h00, 32'd1);
    wr(8'h00, 32'd0);
    rd_chk("abort status", 8'h08, 32'h3);
    wait_neg(20);
    check("abort irq", 32'(irq), 32'd0);
    check("abort ready", 32'(analog_ready), 32'd0);
    rd_chk("abort final status", 8'h08, 32'h0);

    // GUARD=0: one-cycle DISCONNECT and RELEASE
    wr(8'h04, 32'd0);
    wr(8'h00, 32'd1);
    wait_neg(1);
    check("g0 disc io_oeb", 32'(io_oeb), 32'h3F);
    check("g0 disc ready", 32'(analog_ready), 32'd0);
    wait_neg(1);
    check("g0 ready", 32'(analog_ready), 32'd1);
    wr(8'h00, 32'd0);
    wait_neg(1);
    check("g0 rel io_oeb", 32'(io_oeb), 32'h3F);
    wait_neg(1);
    check("g0 dig io_oeb", 32'(io_oeb), 32'h2A);
    wr(8'h08, 32'h10);

    // FORCE_SAFE in DIGITAL
    wr(8'h10, 32'h0);
    wr(8'h0C, 32'h3F);
    wait_neg(1);
    check("fs pre io_oeb", 32'(io_oeb), 32'h0);
    check("fs pre io_out", 32'(io_out), 32'h3F);
    wr(8'h00, 32'd2);
    wait_neg(1);
    check("fs io_oeb", 32'(io_oeb), 32'h3F);
    check("fs io_out", 32'(io_out), 32'h0);
    rd_chk("fs status", 8'h08, 32'h0);
    wr(8'h00, 32'd0);
    wait_neg(1);
    check("fs off io_oeb", 32'(io_oeb), 32'h0);

    // Reset mid-ANALOG
    wr(8'h00, 32'd1);
    wait_neg(3);
    check("pre-rst ready", 32'(analog_ready), 32'd1);
    check("pre-rst irq", 32'(irq), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid-rst io_oeb", 32'(io_oeb), 32'h3F);
    check("mid-rst io_out", 32'(io_out), 32'h0);
    check("mid-rst ready", 32'(analog_ready), 32'd0);
    check("mid-rst irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("post-rst guard", 8'h04, 32'h40);
    rd_chk("post-rst dig_oeb", 8'h10, 32'h3F);
    rd_chk("post-rst ctrl", 8'h00, 32'h0);
    rd_chk("post-rst status", 8'h08, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
